niu32_mem_arbiter: RTL and testbench

Shares one single-port synchronous data/instruction RAM between the Niu32 fetch path (I-port, read-only) and the load/store path (D-port, read/write). It arbitrates round-robin, sequences each access through a 3-state FSM, and decodes the board I/O addresses: HEX, LEDR, LEDG, KEY and SWITCH. It sits between the multicycle core's IR/MAR/MDR logic and the RAM macro.

---
 rtl/niu32_pkg.sv | 34 +++
 rtl/niu32_mem_arbiter_if.sv | 42 ++++
 rtl/niu32_mmio_regs.sv | 77 +++++++
 rtl/niu32_mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_niu32_mem_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/niu32_pkg.sv
// Shared constants and types for the Niu32 memory arbiter.
// ADDR_* are the board I/O locations decoded on the D-port when MMIO is built in.
package niu32_pkg;

    localparam int unsigned WORD_SIZE          = 32;
    localparam int unsigned MEM_ADDR_BITS      = 13;
    localparam int unsigned MEM_WORD_OFFSET    = 2;
    localparam int unsigned MEM_WORD_ADDR_BITS = MEM_ADDR_BITS - MEM_WORD_OFFSET;

    localparam logic [WORD_SIZE-1:0] ADDR_HEX    = 32'hFFFF_0000;
    localparam logic [WORD_SIZE-1:0] ADDR_LEDR   = 32'hFFFF_0020;
    localparam logic [WORD_SIZE-1:0] ADDR_LEDG   = 32'hFFFF_0040;
    localparam logic [WORD_SIZE-1:0] ADDR_KEY    = 32'hFFFF_0100;
    localparam logic [WORD_SIZE-1:0] ADDR_SWITCH = 32'hFFFF_0120;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } arb_state_e;

    typedef enum logic {
        GntI,
        GntD
    } grant_e;

    // Byte address to RAM word address; bits above the RAM window alias.
    function automatic logic [MEM_WORD_ADDR_BITS-1:0] ram_word_addr(
        input logic [WORD_SIZE-1:0] byte_addr
    );
        return byte_addr[MEM_ADDR_BITS-1:MEM_WORD_OFFSET];
    endfunction

endpackage

// File: rtl/niu32_mem_arbiter_if.sv
// Bus bundle between the core fetch/load-store paths, the RAM macro and board I/O.
// slave is the arbiter's view; master is the core/RAM/board side.
interface niu32_mem_arbiter_if;
    import niu32_pkg::*;

    logic                          i_req;
    logic [WORD_SIZE-1:0]          i_addr;
    logic                          i_ack;
    logic [WORD_SIZE-1:0]          i_rdata;

    logic                          d_req;
    logic                          d_we;
    logic [WORD_SIZE-1:0]          d_addr;
    logic [WORD_SIZE-1:0]          d_wdata;
    logic                          d_ack;
    logic [WORD_SIZE-1:0]          d_rdata;

    logic                          mem_en;
    logic                          mem_we;
    logic [MEM_WORD_ADDR_BITS-1:0] mem_addr;
    logic [WORD_SIZE-1:0]          mem_wdata;
    logic [WORD_SIZE-1:0]          mem_rdata;

    logic [3:0]                    key;
    logic [9:0]                    switch;
    logic [15:0]                   hex_out;
    logic [9:0]                    ledr;
    logic [7:0]                    ledg;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, key, switch,
        output i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
        output hex_out, ledr, ledg
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, key, switch,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
        input  hex_out, ledr, ledg
    );

endinterface

// File: rtl/niu32_mmio_regs.sv
// Board I/O registers (HEX/LEDR/LEDG), D-port address decode and read mux.
// Reads are captured during ISSUE so RESP returns a stable value.
module niu32_mmio_regs
    import niu32_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_i,
    input  logic                 we_i,
    input  logic [WORD_SIZE-1:0] addr_i,
    input  logic [WORD_SIZE-1:0] wdata_i,
    input  logic [3:0]           key_i,
    input  logic [9:0]           switch_i,
    output logic                 hit_o,
    output logic [WORD_SIZE-1:0] rdata_o,
    output logic [15:0]          hex_o,
    output logic [9:0]           ledr_o,
    output logic [7:0]           ledg_o
);

    logic [15:0]          hex_q, hex_d;
    logic [9:0]           ledr_q, ledr_d;
    logic [7:0]           ledg_q, ledg_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic sel_hex, sel_ledr, sel_ledg, sel_key, sel_switch;

    assign sel_hex    = (addr_i == ADDR_HEX);
    assign sel_ledr   = (addr_i == ADDR_LEDR);
    assign sel_ledg   = (addr_i == ADDR_LEDG);
    assign sel_key    = (addr_i == ADDR_KEY);
    assign sel_switch = (addr_i == ADDR_SWITCH);
    assign hit_o      = sel_hex | sel_ledr | sel_ledg | sel_key | sel_switch;

    always_comb begin
        hex_d   = hex_q;
        ledr_d  = ledr_q;
        ledg_d  = ledg_q;
        rdata_d = rdata_q;
        if (acc_i && we_i) begin
            // KEY and SWITCH writes fall through and are discarded.
            if (sel_hex)  hex_d  = wdata_i[15:0];
            if (sel_ledr) ledr_d = wdata_i[9:0];
            if (sel_ledg) ledg_d = wdata_i[7:0];
        end
        if (acc_i && !we_i) begin
            rdata_d = '0;
            if (sel_hex)    rdata_d = {16'b0, hex_q};
            if (sel_ledr)   rdata_d = {22'b0, ledr_q};
            if (sel_ledg)   rdata_d = {24'b0, ledg_q};
            if (sel_key)    rdata_d = {28'b0, key_i};
            if (sel_switch) rdata_d = {22'b0, switch_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_q   <= '0;
            ledr_q  <= '0;
            ledg_q  <= '0;
            rdata_q <= '0;
        end else begin
            hex_q   <= hex_d;
            ledr_q  <= ledr_d;
            ledg_q  <= ledg_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;
    assign hex_o   = hex_q;
    assign ledr_o  = ledr_q;
    assign ledg_o  = ledg_q;

    logic unused_wdata;
    assign unused_wdata = ^wdata_i[WORD_SIZE-1:16];

endmodule

// File: rtl/niu32_mem_arbiter.sv
// Round-robin I/D arbiter for the shared single-port RAM (IDLE -> ISSUE -> RESP).
// Board I/O decode on the D-port is built in only when NIU32_MMIO_EN is defined.
module niu32_mem_arbiter
    import niu32_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    niu32_mem_arbiter_if.slave bus
);

    arb_state_e           state_q, state_d;
    grant_e               grant_q, grant_d;
    grant_e               last_grant_q, last_grant_d;
    logic                 we_q, we_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;

    logic                 load;
    grant_e               load_grant;
    logic                 mmio_hit;
    logic                 d_mmio;
    logic                 mmio_acc;
    logic [WORD_SIZE-1:0] mmio_rdata;

    logic                          mem_en, mem_we;
    logic [MEM_WORD_ADDR_BITS-1:0] mem_addr;
    logic [WORD_SIZE-1:0]          mem_wdata;
    logic                          i_ack, d_ack;
    logic [WORD_SIZE-1:0]          i_rdata, d_rdata;

    assign d_mmio   = (grant_q == GntD) && mmio_hit;
    assign mmio_acc = (state_q == StIssue) && d_mmio;

    always_comb begin : next_state
        state_d      = state_q;
        last_grant_d = last_grant_q;
        load         = 1'b0;
        load_grant   = GntI;
        unique case (state_q)
            StIdle: begin
                if (bus.i_req || bus.d_req) begin
                    load    = 1'b1;
                    state_d = StIssue;
                    if (bus.i_req && bus.d_req) begin
                        load_grant = (last_grant_q == GntD) ? GntI : GntD;
                    end else begin
                        load_grant = bus.d_req ? GntD : GntI;
                    end
                end
            end
            StIssue: state_d = StResp;
            StResp: begin
                last_grant_d = grant_q;
                // Only the other port may chain directly; the acked port's req is stale.
                if ((grant_q == GntI) ? bus.d_req : bus.i_req) begin
                    load       = 1'b1;
                    load_grant = (grant_q == GntI) ? GntD : GntI;
                    state_d    = StIssue;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin : latch_req
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (load) begin
            grant_d = load_grant;
            if (load_grant == GntD) begin
                we_d    = bus.d_we;
                addr_d  = bus.d_addr;
                wdata_d = bus.d_wdata;
            end else begin
                we_d    = 1'b0;
                addr_d  = bus.i_addr;
                wdata_d = '0;
            end
        end
    end

    always_comb begin : outputs
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        i_ack     = 1'b0;
        i_rdata   = '0;
        d_ack     = 1'b0;
        d_rdata   = '0;
        unique case (state_q)
            StIssue: begin
                if (!d_mmio) begin
                    mem_en    = 1'b1;
                    mem_we    = we_q;
                    mem_addr  = ram_word_addr(addr_q);
                    mem_wdata = wdata_q;
                end
            end
            StResp: begin
                if (grant_q == GntI) begin
                    i_ack   = 1'b1;
                    i_rdata = bus.mem_rdata;
                end else begin
                    d_ack = 1'b1;
                    if (!we_q) d_rdata = d_mmio ? mmio_rdata : bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= GntI;
            last_grant_q <= GntD;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign bus.mem_en    = mem_en;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.i_ack     = i_ack;
    assign bus.i_rdata   = i_rdata;
    assign bus.d_ack     = d_ack;
    assign bus.d_rdata   = d_rdata;

`ifdef NIU32_MMIO_EN
    logic [15:0] hex_out;
    logic [9:0]  ledr;
    logic [7:0]  ledg;

    niu32_mmio_regs u_mmio_regs (
        .clk      (clk),
        .reset    (reset),
        .acc_i    (mmio_acc),
        .we_i     (we_q),
        .addr_i   (addr_q),
        .wdata_i  (wdata_q),
        .key_i    (bus.key),
        .switch_i (bus.switch),
        .hit_o    (mmio_hit),
        .rdata_o  (mmio_rdata),
        .hex_o    (hex_out),
        .ledr_o   (ledr),
        .ledg_o   (ledg)
    );

    assign bus.hex_out = hex_out;
    assign bus.ledr    = ledr;
    assign bus.ledg    = ledg;
`else
    assign mmio_hit    = 1'b0;
    assign mmio_rdata  = '0;
    assign bus.hex_out = '0;
    assign bus.ledr    = '0;
    assign bus.ledg    = '0;

    logic unused_io;
    assign unused_io = ^{bus.key, bus.switch, mmio_acc,
                         addr_q[WORD_SIZE-1:MEM_ADDR_BITS], addr_q[MEM_WORD_OFFSET-1:0]};
`endif

endmodule

// File: tb/tb_niu32_mem_arbiter.sv
// Directed bench for niu32_mem_arbiter with a registered-read RAM model.
// MMIO checks run when NIU32_MMIO_EN is defined, the RAM-alias checks otherwise.
module tb_niu32_mem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [31:0] ram [0:2047];
    logic [31:0] ram_rdata;

    niu32_mem_arbiter_if bus ();

    niu32_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else            ram_rdata <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = ram_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
        ram[1]    = 32'hA5A5_A5A5;
        ram[2]    = 32'hDEAD_BEEF;
        ram[4]    = 32'h1111_1111;
        ram[8]    = 32'h2222_2222;
        ram_rdata = 32'h0;
        reset     = 1'b1;
        bus.i_req = 1'b0;  bus.i_addr = '0;
        bus.d_req = 1'b0;  bus.d_we = 1'b0;  bus.d_addr = '0;  bus.d_wdata = '0;
        bus.key   = 4'hA;  bus.switch = 10'h155;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_en",    {31'b0, bus.mem_en}, 32'h0);
        chk("rst_mem_we",    {31'b0, bus.mem_we}, 32'h0);
        chk("rst_i_ack",     {31'b0, bus.i_ack},  32'h0);
        chk("rst_d_ack",     {31'b0, bus.d_ack},  32'h0);
        chk("rst_mem_addr",  {21'b0, bus.mem_addr}, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_hex",       {16'b0, bus.hex_out}, 32'h0);
        chk("rst_ledr",      {22'b0, bus.ledr},    32'h0);
        chk("rst_ledg",      {24'b0, bus.ledg},    32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_mem_en", {31'b0, bus.mem_en}, 32'h0);

        // Single fetch
        bus.i_req = 1'b1;  bus.i_addr = 32'h0000_0008;
        @(negedge clk);
        chk("f1_mem_en",   {31'b0, bus.mem_en}, 32'h1);
        chk("f1_mem_we",   {31'b0, bus.mem_we}, 32'h0);
        chk("f1_mem_addr", {21'b0, bus.mem_addr}, 32'h2);
        chk("f1_i_ack_early", {31'b0, bus.i_ack}, 32'h0);
        @(negedge clk);
        chk("f1_i_ack",    {31'b0, bus.i_ack}, 32'h1);
        chk("f1_i_rdata",  bus.i_rdata, 32'hDEAD_BEEF);
        chk("f1_mem_en_one", {31'b0, bus.mem_en}, 32'h0);
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("f1_i_ack_one", {31'b0, bus.i_ack}, 32'h0);
        chk("f1_i_rdata_idle", bus.i_rdata, 32'h0);

        // Tie right after reset: I first, D chained with no IDLE cycle
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.i_req = 1'b1;  bus.i_addr = 32'h0000_0010;
        bus.d_req = 1'b1;  bus.d_we = 1'b0;  bus.d_addr = 32'h0000_0020;
        @(negedge clk);
        chk("tie1_i_addr", {21'b0, bus.mem_addr}, 32'h4);
        @(negedge clk);
        chk("tie1_i_ack",   {31'b0, bus.i_ack}, 32'h1);
        chk("tie1_i_rdata", bus.i_rdata, 32'h1111_1111);
        chk("tie1_d_ack_wait", {31'b0, bus.d_ack}, 32'h0);
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("tie1_d_issue", {31'b0, bus.mem_en}, 32'h1);
        chk("tie1_d_addr",  {21'b0, bus.mem_addr}, 32'h8);
        @(negedge clk);
        chk("tie1_d_ack",   {31'b0, bus.d_ack}, 32'h1);
        chk("tie1_d_rdata", bus.d_rdata, 32'h2222_2222);
        bus.d_req = 1'b0;
        @(negedge clk);

        // Lone fetch leaves I as last served; the following tie must go to D
        bus.i_req = 1'b1;  bus.i_addr = 32'h0000_0008;
        repeat (2) @(negedge clk);
        chk("lone_i_ack", {31'b0, bus.i_ack}, 32'h1);
        bus.i_req = 1'b0;
        @(negedge clk);
        bus.i_req = 1'b1;  bus.i_addr = 32'h0000_0010;
        bus.d_req = 1'b1;  bus.d_addr = 32'h0000_0020;
        @(negedge clk);
        chk("tie2_d_first", {21'b0, bus.mem_addr}, 32'h8);
        @(negedge clk);
        chk("tie2_d_ack", {31'b0, bus.d_ack}, 32'h1);
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("tie2_i_addr", {21'b0, bus.mem_addr}, 32'h4);
        @(negedge clk);
        chk("tie2_i_ack", {31'b0, bus.i_ack}, 32'h1);
        bus.i_req = 1'b0;
        @(negedge clk);

        // RAM write then read-back; D keeps req high to re-request (3-cycle spacing)
        bus.d_req = 1'b1;  bus.d_we = 1'b1;
        bus.d_addr = 32'h0000_010C;  bus.d_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("wr_mem_en",    {31'b0, bus.mem_en}, 32'h1);
        chk("wr_mem_we",    {31'b0, bus.mem_we}, 32'h1);
        chk("wr_mem_addr",  {21'b0, bus.mem_addr}, 32'h43);
        chk("wr_mem_wdata", bus.mem_wdata, 32'h1234_5678);
        @(negedge clk);
        chk("wr_d_ack",   {31'b0, bus.d_ack}, 32'h1);
        chk("wr_d_rdata", bus.d_rdata, 32'h0);
        bus.d_we = 1'b0;  bus.d_wdata = '0;
        @(negedge clk);
        chk("rerq_idle", {31'b0, bus.mem_en}, 32'h0);
        @(negedge clk);
        chk("rerq_issue", {31'b0, bus.mem_en}, 32'h1);
        @(negedge clk);
        chk("rd_d_ack",   {31'b0, bus.d_ack}, 32'h1);
        chk("rd_d_rdata", bus.d_rdata, 32'h1234_5678);
        bus.d_req = 1'b0;
        @(negedge clk);

`ifdef NIU32_MMIO_EN
        bus.d_req = 1'b1;  bus.d_we = 1'b1;
        bus.d_addr = 32'hFFFF_0020;  bus.d_wdata = 32'h0000_03FF;
        @(negedge clk);
        chk("ledr_wr_mem_en", {31'b0, bus.mem_en}, 32'h0);
        @(negedge clk);
        chk("ledr_wr_ack", {31'b0, bus.d_ack}, 32'h1);
        chk("ledr_val",    {22'b0, bus.ledr}, 32'h3FF);
        bus.d_req = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b1;  bus.d_we = 1'b1;
        bus.d_addr = 32'hFFFF_0000;  bus.d_wdata = 32'hABCD_1234;
        repeat (2) @(negedge clk);
        chk("hex_val", {16'b0, bus.hex_out}, 32'h1234);
        bus.d_req = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b1;  bus.d_we = 1'b0;  bus.d_addr = 32'hFFFF_0000;
        repeat (2) @(negedge clk);
        chk("hex_rd", bus.d_rdata, 32'h0000_1234);
        bus.d_req = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b1;  bus.d_addr = 32'hFFFF_0120;
        @(negedge clk);
        chk("sw_rd_mem_en", {31'b0, bus.mem_en}, 32'h0);
        @(negedge clk);
        chk("sw_rd", bus.d_rdata, 32'h0000_0155);
        bus.d_req = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b1;  bus.d_addr = 32'hFFFF_0100;
        repeat (2) @(negedge clk);
        chk("key_rd", bus.d_rdata, 32'h0000_000A);
        bus.d_req = 1'b0;
        @(negedge clk);
`else
        bus.d_req = 1'b1;  bus.d_we = 1'b0;  bus.d_addr = 32'h0000_2004;
        @(negedge clk);
        chk("alias_mem_addr", {21'b0, bus.mem_addr}, 32'h1);
        @(negedge clk);
        chk("alias_rdata", bus.d_rdata, 32'hA5A5_A5A5);
        bus.d_req = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b1;  bus.d_we = 1'b1;
        bus.d_addr = 32'hFFFF_0020;  bus.d_wdata = 32'h0000_03FF;
        @(negedge clk);
        chk("nommio_mem_en",   {31'b0, bus.mem_en}, 32'h1);
        chk("nommio_mem_addr", {21'b0, bus.mem_addr}, 32'h8);
        @(negedge clk);
        chk("nommio_ledr", {22'b0, bus.ledr}, 32'h0);
        bus.d_req = 1'b0;  bus.d_we = 1'b0;
        @(negedge clk);
`endif

        // Reset during ISSUE aborts; held request is re-served after release
        bus.i_req = 1'b1;  bus.i_addr = 32'h0000_0008;
        @(negedge clk);
        chk("abort_issue", {31'b0, bus.mem_en}, 32'h1);
        reset = 1'b1;
        #1;
        chk("abort_mem_en", {31'b0, bus.mem_en}, 32'h0);
        chk("abort_mem_addr", {21'b0, bus.mem_addr}, 32'h0);
        @(negedge clk);
        chk("abort_no_ack", {31'b0, bus.i_ack}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("reserve_issue", {31'b0, bus.mem_en}, 32'h1);
        @(negedge clk);
        chk("reserve_ack",   {31'b0, bus.i_ack}, 32'h1);
        chk("reserve_rdata", bus.i_rdata, 32'hDEAD_BEEF);
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("final_idle", {31'b0, bus.i_ack}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
